spi_flash_bist: RTL and testbench
=================================

# spi_flash_bist

Parametrised built-in self-test sequencer for the SPI flash path. It drives the flash controller's byte-level request/ack interface through a complete cycle: sector erase, blank check, page program of a NUM_BYTES pattern, and read-back verify. It reports pass/fail, a saturating error count, and the first failing address. It replaces the fixed single-byte key-driven exerciser, sits between the debounced key/board logic and the flash controller, and feeds the seven-segment display.

## Interface
- NUM_BYTES, 16: bytes tested per run; legal range 1..256, which must stay within one page.
- BASE_ADDR, 24'h000000: first flash address; sector aligned.
- IDLE_WAIT, 4: cycles waited after start before the first request.
- ERR_W, 8: error counter width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse (debounced key) that begins a run; ignored while busy.
- mode  in  2  pattern/flow select, sampled at start.
- seed  in  8  pattern seed, sampled at start.
- flash_rd_req / flash_pp_req / flash_se_req  out  1 each  request strobes, at most one high.
- flash_addr  out  24  transaction address.
- flash_wdata  out  8  program byte.
- flash_rdata  in  8  read byte, valid in the flash_ack cycle.
- flash_ack  in  1  one-cycle transaction-complete pulse.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- pass  out  1  done and err_cnt==0.
- err_cnt  out  ERR_W  mismatch count, saturating at all-ones.
- fail_addr  out  24  address of the first mismatch; 24'hFFFFFF if none.
- last_rdata  out  8  most recent byte read, for the display.

## Operation
- Pattern p(i) for i = 0..NUM_BYTES-1, using 8-bit wrap arithmetic:
  - mode 0: seed+i
  - mode 1: seed
  - mode 2: seed ^ i[7:0]
  - mode 3: same as mode 0, but erase and program are skipped (verify-only).
- States: S_IDLE, S_WAIT, S_SE, S_BLANK, S_PP, S_VERIFY, S_DONE.
- S_IDLE / S_DONE, on start:
  - latch mode and seed; clear err_cnt, set fail_addr=24'hFFFFFF, clear done; set busy.
  - go to S_WAIT.
- S_WAIT: count IDLE_WAIT cycles, then go to S_SE, or to S_VERIFY when mode==3.
- S_SE: one se_req at BASE_ADDR. On ack, go to S_BLANK with i=0.
- S_BLANK: rd_req at BASE_ADDR+i. Expected value is 8'hFF.
- S_PP: pp_req at BASE_ADDR+i with wdata=p(i).
- S_VERIFY: rd_req at BASE_ADDR+i. Expected value is p(i).
- Per-byte states: on ack, increment i. After byte NUM_BYTES-1, advance S_BLANK→S_PP→S_VERIFY→S_DONE, resetting i to 0 at each transition.
- Mismatch (read states only), in the ack cycle:
  - err_cnt increments unless already saturated.
  - fail_addr is loaded only if it still holds 24'hFFFFFF.
- last_rdata updates on every read ack.
- Blank-check errors do not stop the run.
- S_DONE: busy=0, done=1.
- flash_ack outside a request-pending cycle is ignored.

## Timing
- Reset values:
  - all req=0, flash_addr=0, flash_wdata=0
  - busy=0, done=0, pass=0, err_cnt=0
  - fail_addr=24'hFFFFFF, last_rdata=8'h00
  - state S_IDLE, i=0.
- Reset mid-run forces reset values at that edge; all reqs drop immediately.
- All outputs are registered.
- Start sampled at edge N:
  - busy=1 from edge N.
  - First req high from edge N+1+IDLE_WAIT.
- Request handshake:
  - A req stays high until the edge after its ack cycle; flash_addr and flash_wdata are stable for the whole time req is high.
  - Between consecutive transactions, req is low for exactly one cycle.
  - The next req rises, with its new address, on the following edge.
- err_cnt, fail_addr, last_rdata update on the edge ending the ack cycle.
- done and pass rise on the edge after the final verify ack.
- start coinciding with reset: reset wins.
- start coinciding with ack: the start is ignored (busy).
- Address arithmetic: BASE_ADDR + i, 24-bit; no page crossing by construction.

## Test plan
- Flash model returns programmed data; mode 0, seed 8'h11, NUM_BYTES 16 → sequence is 1 se, 16 blank reads, 16 pp with wdata 11..20, 16 reads; done=1, pass=1, err_cnt=0, fail_addr=FFFFFF.
- Model corrupts the byte at BASE+5 in verify, mode 1, seed A5 → err_cnt=1, fail_addr=000005, pass=0, last_rdata = byte read at BASE+15.
- Model returns 00 for every read, mode 2, seed 3C, ERR_W=4 → err_cnt saturates at 15 (32 mismatches), fail_addr=000000.
- Mode 3, seed 40 → no se or pp issued; 16 reads expecting 40..4F; first req appears IDLE_WAIT+1 cycles after start.
- Reset asserted during S_PP byte 7 → next edge: all reqs=0, busy=0, err_cnt=0. Start again → run completes, pass=1.
- Start pulses while busy, and ack pulses in gap cycles → no restart; the transaction count is unchanged.

Source files
------------

// File: rtl/spi_flash_bist.sv
// spi_flash_bist
// Built-in self-test sequencer for the SPI flash path. One run erases the
// sector at BASE_ADDR, blank-checks NUM_BYTES bytes, programs a seeded
// pattern, then reads it back and compares. Mode 3 skips erase/program and
// only verifies.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 one-cycle run request (ignored while busy)
//   mode[1:0], seed[7:0]  pattern select and seed, latched at start
//   flash_*_req           read / page-program / sector-erase strobes
//   flash_addr, flash_wdata  transaction address and program byte
//   flash_rdata, flash_ack   read byte and one-cycle completion pulse
//   busy, done, pass      run status
//   err_cnt               saturating mismatch count
//   fail_addr             first mismatching address, all-ones if none
//   last_rdata            most recent byte read
module spi_flash_bist #(
    parameter int          NUM_BYTES = 16,
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter int          IDLE_WAIT = 4,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [7:0]       seed,
    output logic             flash_rd_req,
    output logic             flash_pp_req,
    output logic             flash_se_req,
    output logic [23:0]      flash_addr,
    output logic [7:0]       flash_wdata,
    input  logic [7:0]       flash_rdata,
    input  logic             flash_ack,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [23:0]      fail_addr,
    output logic [7:0]       last_rdata
);

    localparam int          WAIT_W   = (IDLE_WAIT < 1) ? 1 : $clog2(IDLE_WAIT + 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_BYTES - 1);
    localparam logic [23:0] NO_FAIL  = 24'hFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SE, S_BLANK, S_PP, S_VERIFY, S_DONE
    } state_t;

    state_t              state_q;
    logic [7:0]          idx_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [1:0]          mode_q;
    logic [7:0]          seed_q;
    logic                rd_req_q, pp_req_q, se_req_q;
    logic [23:0]         addr_q;
    logic [7:0]          wdata_q;
    logic                busy_q, done_q, pass_q;
    logic [ERR_W-1:0]    err_cnt_q;
    logic [23:0]         fail_addr_q;
    logic [7:0]          last_rdata_q;

    logic [7:0]          pat_d;
    logic [7:0]          exp_d;
    logic                mismatch_d;
    logic [ERR_W-1:0]    err_cnt_d;
    logic                req_any;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        pat_d = seed_q + idx_q;
        case (mode_q)
            2'd1:    pat_d = seed_q;
            2'd2:    pat_d = seed_q ^ idx_q;
            default: pat_d = seed_q + idx_q;
        endcase
        exp_d      = (state_q == S_BLANK) ? 8'hFF : pat_d;
        mismatch_d = ((state_q == S_BLANK) || (state_q == S_VERIFY)) && (flash_rdata != exp_d);
        err_cnt_d  = mismatch_d ? sat_inc(err_cnt_q) : err_cnt_q;
    end

    assign req_any = rd_req_q | pp_req_q | se_req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            wait_q       <= '0;
            mode_q       <= '0;
            seed_q       <= '0;
            rd_req_q     <= 1'b0;
            pp_req_q     <= 1'b0;
            se_req_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_addr_q  <= NO_FAIL;
            last_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q      <= mode;
                        seed_q      <= seed;
                        err_cnt_q   <= '0;
                        fail_addr_q <= NO_FAIL;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        wait_q      <= '0;
                        idx_q       <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The first request is raised on the same edge that
                    // leaves S_WAIT, so it appears IDLE_WAIT+1 edges after start.
                    if (wait_q == WAIT_W'(IDLE_WAIT)) begin
                        idx_q  <= '0;
                        addr_q <= BASE_ADDR;
                        if (mode_q == 2'd3) begin
                            state_q  <= S_VERIFY;
                            rd_req_q <= 1'b1;
                        end else begin
                            state_q  <= S_SE;
                            se_req_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_SE: begin
                    if (se_req_q && flash_ack) begin
                        se_req_q <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= S_BLANK;
                    end
                end
                S_BLANK, S_PP, S_VERIFY: begin
                    if (!req_any) begin
                        // Gap cycle: launch the transaction for the current byte.
                        addr_q <= BASE_ADDR + {16'h0000, idx_q};
                        if (state_q == S_PP) begin
                            pp_req_q <= 1'b1;
                            wdata_q  <= pat_d;
                        end else begin
                            rd_req_q <= 1'b1;
                        end
                    end else if (flash_ack) begin
                        rd_req_q <= 1'b0;
                        pp_req_q <= 1'b0;
                        if (state_q != S_PP) begin
                            last_rdata_q <= flash_rdata;
                            err_cnt_q    <= err_cnt_d;
                            if (mismatch_d && (fail_addr_q == NO_FAIL))
                                fail_addr_q <= addr_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            case (state_q)
                                S_BLANK: state_q <= S_PP;
                                S_PP:    state_q <= S_VERIFY;
                                default: begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    pass_q  <= (err_cnt_d == '0);
                                end
                            endcase
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign flash_rd_req = rd_req_q;
    assign flash_pp_req = pp_req_q;
    assign flash_se_req = se_req_q;
    assign flash_addr   = addr_q;
    assign flash_wdata  = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_cnt_q;
    assign fail_addr    = fail_addr_q;
    assign last_rdata   = last_rdata_q;

endmodule

// File: tb/tb_spi_flash_bist.sv
// Directed bench for spi_flash_bist with a behavioural flash model that
// acknowledges each request after a short latency, keeps a byte array,
// and logs every transaction for later comparison.
module tb_spi_flash_bist;

    localparam int ERR_W = 4;
    localparam int LAT   = 1;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [1:0]       mode;
    logic [7:0]       seed;
    logic             flash_rd_req, flash_pp_req, flash_se_req;
    logic [23:0]      flash_addr;
    logic [7:0]       flash_wdata;
    logic [7:0]       flash_rdata = 8'h00;
    logic             flash_ack = 1'b0;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
    logic [23:0]      fail_addr;
    logic [7:0]       last_rdata;

    spi_flash_bist #(
        .NUM_BYTES(16), .BASE_ADDR(24'h000000), .IDLE_WAIT(4), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .flash_rd_req(flash_rd_req), .flash_pp_req(flash_pp_req),
        .flash_se_req(flash_se_req), .flash_addr(flash_addr),
        .flash_wdata(flash_wdata), .flash_rdata(flash_rdata),
        .flash_ack(flash_ack), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .last_rdata(last_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Flash model state
    logic [7:0]  mem [256];
    logic [7:0]  pp_log [256];
    logic [23:0] pp_addr_log [256];
    logic [23:0] se_addr_last = 24'h123456;
    int          se_cnt = 0, pp_cnt = 0, rd_cnt = 0;
    int          hs_err = 0;
    int          lat = 0;
    int          gap_st = 0;
    int          rd_mode = 0;     // 0 normal, 1 corrupt programmed byte 5, 2 zeros, 3 40+addr
    logic        stray_en = 1'b0;
    logic        prev_req = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [7:0]  prev_wdata = '0;

    always @(negedge clk) begin
        logic ra;
        logic [7:0] a;
        ra = flash_rd_req | flash_pp_req | flash_se_req;
        a  = flash_addr[7:0];
        if ((int'(flash_rd_req) + int'(flash_pp_req) + int'(flash_se_req)) > 1) hs_err++;
        if (ra && prev_req && (flash_addr !== prev_addr || flash_wdata !== prev_wdata)) hs_err++;
        if (gap_st == 1) begin
            if (ra) hs_err++;
            gap_st = 2;
        end else if (gap_st == 2) begin
            if (busy && !ra) hs_err++;
            gap_st = 0;
        end
        prev_req   = ra;
        prev_addr  = flash_addr;
        prev_wdata = flash_wdata;
        if (flash_ack) begin
            flash_ack = 1'b0;
            lat = 0;
        end else if (ra) begin
            if (lat == LAT) begin
                lat = 0;
                if (flash_se_req) begin
                    se_cnt++;
                    se_addr_last = flash_addr;
                    for (int k = 0; k < 256; k++) mem[k] = 8'hFF;
                end else if (flash_pp_req) begin
                    mem[a] = flash_wdata;
                    pp_log[pp_cnt] = flash_wdata;
                    pp_addr_log[pp_cnt] = flash_addr;
                    pp_cnt++;
                end else begin
                    rd_cnt++;
                    case (rd_mode)
                        1:       flash_rdata = (a == 8'd5 && mem[a] != 8'hFF) ? (mem[a] ^ 8'h01) : mem[a];
                        2:       flash_rdata = 8'h00;
                        3:       flash_rdata = 8'h40 + a;
                        default: flash_rdata = mem[a];
                    endcase
                end
                flash_ack = 1'b1;
                gap_st = 1;
            end else begin
                lat++;
            end
        end else begin
            lat = 0;
            if (stray_en) flash_ack = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int se_b, pp_b, rd_b;

    task automatic start_run(input logic [1:0] m, input logic [7:0] s, input string tag);
        int n;
        se_b = se_cnt; pp_b = pp_cnt; rd_b = rd_cnt;
        @(negedge clk);
        mode = m; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
        n = 0;
        while (!(flash_rd_req | flash_pp_req | flash_se_req) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_first_req_lat"}, n, 5);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mode = 2'd0; seed = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_reqs", {flash_se_req, flash_pp_req, flash_rd_req}, 3'b000);
        chk("rst_addr", flash_addr, 24'h000000);
        chk("rst_wdata", flash_wdata, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fail_addr", fail_addr, 24'hFFFFFF);
        chk("rst_last", last_rdata, 8'h00);
        reset = 1'b0;

        // Full run, clean flash
        rd_mode = 0;
        start_run(2'd0, 8'h11, "t1");
        chk("t1_first_is_se", {flash_se_req, flash_pp_req, flash_rd_req}, 3'b100);
        wait_done("t1");
        chk("t1_se_cnt", se_cnt - se_b, 1);
        chk("t1_se_addr", se_addr_last, 24'h000000);
        chk("t1_pp_cnt", pp_cnt - pp_b, 16);
        chk("t1_rd_cnt", rd_cnt - rd_b, 32);
        chk("t1_wdata0", pp_log[pp_b], 8'h11);
        chk("t1_wdata7", pp_log[pp_b + 7], 8'h18);
        chk("t1_wdata15", pp_log[pp_b + 15], 8'h20);
        chk("t1_ppaddr15", pp_addr_log[pp_b + 15], 24'h00000F);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_fail_addr", fail_addr, 24'hFFFFFF);
        chk("t1_last", last_rdata, 8'h20);

        // Single corrupted verify byte at address 5
        rd_mode = 1;
        start_run(2'd1, 8'hA5, "t2");
        wait_done("t2");
        chk("t2_wdata3", pp_log[pp_b + 3], 8'hA5);
        chk("t2_err", err_cnt, 1);
        chk("t2_fail_addr", fail_addr, 24'h000005);
        chk("t2_pass", pass, 0);
        chk("t2_last", last_rdata, 8'hA5);

        // Every read returns zero: counter saturates
        rd_mode = 2;
        start_run(2'd2, 8'h3C, "t3");
        wait_done("t3");
        chk("t3_wdata5", pp_log[pp_b + 5], 8'h39);
        chk("t3_rd_cnt", rd_cnt - rd_b, 32);
        chk("t3_err_sat", err_cnt, 4'hF);
        chk("t3_fail_addr", fail_addr, 24'h000000);
        chk("t3_pass", pass, 0);
        chk("t3_last", last_rdata, 8'h00);

        // Verify-only mode
        rd_mode = 3;
        start_run(2'd3, 8'h40, "t4");
        chk("t4_first_is_rd", {flash_se_req, flash_pp_req, flash_rd_req}, 3'b001);
        wait_done("t4");
        chk("t4_se_cnt", se_cnt - se_b, 0);
        chk("t4_pp_cnt", pp_cnt - pp_b, 0);
        chk("t4_rd_cnt", rd_cnt - rd_b, 16);
        chk("t4_err", err_cnt, 0);
        chk("t4_pass", pass, 1);
        chk("t4_last", last_rdata, 8'h4F);

        // Reset in the middle of programming byte 7
        rd_mode = 2;
        start_run(2'd0, 8'h11, "t5a");
        n = 0;
        while (!(flash_pp_req && flash_addr == 24'h000007) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_pp7", {flash_pp_req, flash_addr}, {1'b1, 24'h000007});
        chk("t5_err_before", err_cnt, 4'hF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_reqs", {flash_se_req, flash_pp_req, flash_rd_req}, 3'b000);
        chk("t5_busy", busy, 0);
        chk("t5_err", err_cnt, 0);
        chk("t5_fail_addr", fail_addr, 24'hFFFFFF);
        chk("t5_addr", flash_addr, 24'h000000);
        rd_mode = 0;
        start_run(2'd0, 8'h11, "t5b");
        wait_done("t5b");
        chk("t5b_pp_cnt", pp_cnt - pp_b, 16);
        chk("t5b_pass", pass, 1);
        chk("t5b_err", err_cnt, 0);

        // Start pulses while busy and acks in gap cycles
        stray_en = 1'b1;
        start_run(2'd0, 8'h22, "t6");
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            #1;
            if (flash_ack && busy) break;
            n++;
        end
        chk("t6_saw_ack", flash_ack, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t6");
        stray_en = 1'b0;
        chk("t6_se_cnt", se_cnt - se_b, 1);
        chk("t6_pp_cnt", pp_cnt - pp_b, 16);
        chk("t6_rd_cnt", rd_cnt - rd_b, 32);
        chk("t6_wdata0", pp_log[pp_b], 8'h22);
        chk("t6_wdata15", pp_log[pp_b + 15], 8'h31);
        chk("t6_pass", pass, 1);

        repeat (4) @(negedge clk);
        chk("handshake_violations", hs_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
